snax_mx_streamer_csr_sequencer: RTL and testbench

SNAX_MX_STREAMER_CSR_SEQUENCER -- requirements
Module: snax_mx_streamer_csr_sequencer

---
 rtl/snax_mx_sequencer_pkg.sv | 30 +++
 rtl/snax_mx_cfg_shadow_regs.sv | 40 ++++
 rtl/snax_mx_streamer_csr_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_snax_mx_streamer_csr_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snax_mx_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// snax_mx_sequencer_pkg
// Shared definitions for the SNAX MX streamer CSR sequencer:
//   - seq_state_e : states of the launch sequence
//   - StartValue  : word written to the streamer start register
//   - idxWidth()  : index width helper that never returns zero
// -----------------------------------------------------------------------------
package snax_mx_sequencer_pkg;

   // The launch sequence walks these states in order; POLL_REQ/POLL_RSP loop
   // until the streamer reports idle or the poll budget runs out.
   typedef enum logic [2:0] {
      IDLE,
      CFG_WR,
      START_WR,
      POLL_REQ,
      POLL_RSP,
      DONE
   } seq_state_e;

   // Value written to the streamer start register to kick it off.
   localparam logic [31:0] StartValue = 32'h1;

   // Width of an index into n entries; a single entry still gets one bit so
   // that no zero-width vectors are ever declared.
   function automatic int unsigned idxWidth(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snax_mx_cfg_shadow_regs.sv
// -----------------------------------------------------------------------------
// snax_mx_cfg_shadow_regs
// Shadow copy of the streamer configuration words, written by the host and
// read out word by word while a launch replays them to the streamer.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset (clears all)
//   wr_en_i/wr_idx_i/wr_data_i  write port (gating is done by the caller)
//   rd_idx_i / rd_data_o        combinational indexed read port
// -----------------------------------------------------------------------------
module snax_mx_cfg_shadow_regs #(
   parameter int unsigned NumRegs = 16,
   parameter int unsigned IdxW    = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            wr_en_i,
   input  logic [IdxW-1:0] wr_idx_i,
   input  logic [31:0]     wr_data_i,
   input  logic [IdxW-1:0] rd_idx_i,
   output logic [31:0]     rd_data_o
);

   logic [31:0] regs_q [NumRegs];

   // Storage: reset clears every word; writes to an index beyond the file
   // (possible when NumRegs is not a power of two) are dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NumRegs); i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en_i && (32'(wr_idx_i) < NumRegs)) begin
         regs_q[wr_idx_i] <= wr_data_i;
      end
   end

   // Read port: out-of-range indices return zero rather than X.
   assign rd_data_o = (32'(rd_idx_i) < NumRegs) ? regs_q[rd_idx_i] : '0;

endmodule

// File: rtl/snax_mx_streamer_csr_sequencer.sv
// -----------------------------------------------------------------------------
// snax_mx_streamer_csr_sequencer
// On each accepted launch, replays the shadow config words to the streamer
// over its CSR request channel, writes the start register, then polls the
// status register until the streamer is idle (or a poll budget expires),
// and finally pulses done_o.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   cfg_wr_en_i/idx_i/data_i         host writes into the shadow file (IDLE only)
//   launch_valid_i / launch_ready_o  launch handshake
//   busy_o, done_o, error_o          sequence status (error_o = poll timeout)
//   csr_req_*                        streamer CSR request channel
//   csr_rsp_*                        streamer CSR read response channel
// -----------------------------------------------------------------------------
module snax_mx_streamer_csr_sequencer
   import snax_mx_sequencer_pkg::*;
#(
   parameter int unsigned NumCfgRegs  = 16,
   parameter logic [31:0] CsrBaseAddr = 32'h3c0,
   parameter logic [31:0] StartAddr   = CsrBaseAddr + NumCfgRegs,
   parameter logic [31:0] StatusAddr  = StartAddr + 32'd1,
   parameter logic [31:0] BusyMask    = 32'h1,
   parameter int unsigned MaxPolls    = 1024,
   localparam int unsigned IdxW       = idxWidth(NumCfgRegs),
   localparam int unsigned PollW      = $clog2(MaxPolls + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cfg_wr_en_i,
   input  logic [IdxW-1:0] cfg_wr_idx_i,
   input  logic [31:0]     cfg_wr_data_i,
   input  logic            launch_valid_i,
   output logic            launch_ready_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            error_o,
   output logic [31:0]     csr_req_bits_data_o,
   output logic [31:0]     csr_req_bits_addr_o,
   output logic            csr_req_bits_write_o,
   output logic            csr_req_valid_o,
   input  logic            csr_req_ready_i,
   input  logic [31:0]     csr_rsp_bits_data_i,
   input  logic            csr_rsp_valid_i,
   output logic            csr_rsp_ready_o
);

   localparam logic [IdxW-1:0]  CntLast  = IdxW'(NumCfgRegs - 1);
   localparam logic [PollW-1:0] PollLast = PollW'(MaxPolls);

   seq_state_e       state_q;
   logic [IdxW-1:0]  cnt_q;
   logic [PollW-1:0] poll_q;
   logic             error_q;

   logic        launchAccept;
   logic        reqHandshake;
   logic        rspHandshake;
   logic        statusBusy;
   logic        shadowWrEn;
   logic [31:0] shadowRdData;

   assign launchAccept = launch_valid_i && launch_ready_o;
   assign reqHandshake = csr_req_valid_o && csr_req_ready_i;
   assign rspHandshake = csr_rsp_valid_i && csr_rsp_ready_o;
   assign statusBusy   = (csr_rsp_bits_data_i & BusyMask) != '0;

   // The shadow file only accepts host writes while idle, which freezes the
   // image for the whole launch. A write in the launch cycle itself lands
   // before the first CFG_WR cycle reads it, so that launch sees the new value.
   assign shadowWrEn = cfg_wr_en_i && (state_q == IDLE);

   snax_mx_cfg_shadow_regs #(
      .NumRegs (NumCfgRegs),
      .IdxW    (IdxW)
   ) i_shadow (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (shadowWrEn),
      .wr_idx_i  (cfg_wr_idx_i),
      .wr_data_i (cfg_wr_data_i),
      .rd_idx_i  (cnt_q),
      .rd_data_o (shadowRdData)
   );

   // Sequencer FSM. Counters are left at zero when not in use so that the
   // shadow read index and poll count always start clean. The poll counter
   // stops at MaxPolls and never wraps.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         poll_q  <= '0;
         error_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (launchAccept) begin
                  state_q <= CFG_WR;
                  cnt_q   <= '0;
                  error_q <= 1'b0;
               end
            end
            CFG_WR: begin
               if (reqHandshake) begin
                  if (cnt_q == CntLast) begin
                     state_q <= START_WR;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            START_WR: begin
               if (reqHandshake) begin
                  state_q <= POLL_REQ;
                  poll_q  <= '0;
               end
            end
            POLL_REQ: begin
               if (reqHandshake) begin
                  state_q <= POLL_RSP;
                  if (poll_q != PollLast) begin
                     poll_q <= poll_q + 1'b1;
                  end
               end
            end
            POLL_RSP: begin
               if (rspHandshake) begin
                  if (!statusBusy) begin
                     state_q <= DONE;
                  end else if (poll_q < PollLast) begin
                     state_q <= POLL_REQ;
                  end else begin
                     error_q <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               poll_q  <= '0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // CSR request channel. Everything here is decoded from registered state
   // only, so a raised request holds its address and data until the
   // handshake and valid never looks at ready.
   always_comb begin
      csr_req_valid_o      = 1'b0;
      csr_req_bits_addr_o  = '0;
      csr_req_bits_data_o  = '0;
      csr_req_bits_write_o = 1'b0;
      case (state_q)
         CFG_WR: begin
            csr_req_valid_o      = 1'b1;
            csr_req_bits_addr_o  = CsrBaseAddr + 32'(cnt_q);
            csr_req_bits_data_o  = shadowRdData;
            csr_req_bits_write_o = 1'b1;
         end
         START_WR: begin
            csr_req_valid_o      = 1'b1;
            csr_req_bits_addr_o  = StartAddr;
            csr_req_bits_data_o  = StartValue;
            csr_req_bits_write_o = 1'b1;
         end
         POLL_REQ: begin
            csr_req_valid_o      = 1'b1;
            csr_req_bits_addr_o  = StatusAddr;
         end
         default: begin
         end
      endcase
   end

   // Status outputs, all decoded from registered state.
   assign launch_ready_o  = (state_q == IDLE);
   assign busy_o          = (state_q != IDLE);
   assign done_o          = (state_q == DONE);
   assign csr_rsp_ready_o = (state_q == POLL_RSP);
   assign error_o         = error_q;

endmodule

// File: tb/tb_snax_mx_streamer_csr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snax_mx_streamer_csr_sequencer
// Bench for the streamer CSR sequencer. Instance A (4 config words, 8 polls)
// carries most of the traffic; instance B (4 words, 2 polls, streamer always
// busy) exercises the poll timeout at a tiny budget.
// -----------------------------------------------------------------------------
module tb_snax_mx_streamer_csr_sequencer;

   localparam int unsigned NumCfg     = 4;
   localparam logic [31:0] BaseAddr   = 32'h3c0;
   localparam logic [31:0] StartAddr  = 32'h3c4;
   localparam logic [31:0] StatusAddr = 32'h3c5;
   localparam int unsigned MaxPollsA  = 8;
   localparam int unsigned MaxPollsB  = 2;
   localparam int          CycleLimit = 300;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        write;
   } req_t;

   logic        clk;
   logic        rst;

   logic        cfgWrEn;
   logic [1:0]  cfgWrIdx;
   logic [31:0] cfgWrData;
   logic        launchValid;
   logic        launchReady;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] reqData;
   logic [31:0] reqAddr;
   logic        reqWrite;
   logic        reqValid;
   logic        reqReady;
   logic [31:0] rspData;
   logic        rspValid;
   logic        rspReady;

   logic        launchValidB;
   logic        launchReadyB;
   logic        busyB;
   logic        doneB;
   logic        errorB;
   logic [31:0] reqDataB;
   logic [31:0] reqAddrB;
   logic        reqWriteB;
   logic        reqValidB;
   logic        reqReadyB;
   logic [31:0] rspDataB;
   logic        rspValidB;
   logic        rspReadyB;
   logic        cfgWrEnB;
   logic [1:0]  cfgWrIdxB;
   logic [31:0] cfgWrDataB;

   int totalChecks = 0;
   int badChecks   = 0;

   logic [31:0] shadowModel [NumCfg];
   req_t        reqLog[$];
   int          readsB = 0;
   int          donesB = 0;

   snax_mx_streamer_csr_sequencer #(
      .NumCfgRegs (NumCfg),
      .CsrBaseAddr(BaseAddr),
      .MaxPolls   (MaxPollsA)
   ) dutA (
      .clk_i               (clk),
      .rst_i               (rst),
      .cfg_wr_en_i         (cfgWrEn),
      .cfg_wr_idx_i        (cfgWrIdx),
      .cfg_wr_data_i       (cfgWrData),
      .launch_valid_i      (launchValid),
      .launch_ready_o      (launchReady),
      .busy_o              (busy),
      .done_o              (done),
      .error_o             (error),
      .csr_req_bits_data_o (reqData),
      .csr_req_bits_addr_o (reqAddr),
      .csr_req_bits_write_o(reqWrite),
      .csr_req_valid_o     (reqValid),
      .csr_req_ready_i     (reqReady),
      .csr_rsp_bits_data_i (rspData),
      .csr_rsp_valid_i     (rspValid),
      .csr_rsp_ready_o     (rspReady)
   );

   snax_mx_streamer_csr_sequencer #(
      .NumCfgRegs (NumCfg),
      .CsrBaseAddr(BaseAddr),
      .MaxPolls   (MaxPollsB)
   ) dutB (
      .clk_i               (clk),
      .rst_i               (rst),
      .cfg_wr_en_i         (cfgWrEnB),
      .cfg_wr_idx_i        (cfgWrIdxB),
      .cfg_wr_data_i       (cfgWrDataB),
      .launch_valid_i      (launchValidB),
      .launch_ready_o      (launchReadyB),
      .busy_o              (busyB),
      .done_o              (doneB),
      .error_o             (errorB),
      .csr_req_bits_data_o (reqDataB),
      .csr_req_bits_addr_o (reqAddrB),
      .csr_req_bits_write_o(reqWriteB),
      .csr_req_valid_o     (reqValidB),
      .csr_req_ready_i     (reqReadyB),
      .csr_rsp_bits_data_i (rspDataB),
      .csr_rsp_valid_i     (rspValidB),
      .csr_rsp_ready_o     (rspReadyB)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance B monitor: counts status reads that will handshake on the
   // coming edge, and done pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (reqValidB && reqReadyB && !reqWriteB && reqAddrB == StatusAddr) readsB++;
      if (doneB) donesB++;
   end

   // Single comparison point: counts the check and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Host write into the shadow file while idle; the model takes it too.
   task automatic applyStimulus(input logic [1:0] idx, input logic [31:0] data);
      cfgWrEn   = 1'b1;
      cfgWrIdx  = idx;
      cfgWrData = data;
      shadowModel[idx] = data;
      @(negedge clk);
      cfgWrEn = 1'b0;
   endtask

   // One full launch on instance A. The expected transaction list comes from
   // the model: every shadow word in order, the start write, then status
   // reads until a non-busy reply or the poll budget is spent.
   task automatic runLaunch(input int stallWord, input int busyCount,
                            input bit randomReady, input int maxDelay,
                            input bit busyWrite, input bit sameCycleWrite);
      req_t        expList[$];
      req_t        cur;
      req_t        prevReq;
      bit          prevStall;
      bit          readOut;
      int          delay;
      int          readsSent;
      int          stallLeft;
      int          doneCount;
      int          doneCycle;
      int          expReads;
      bit          timeoutExp;
      logic [1:0]  idx;
      logic [31:0] wdata;

      reqLog.delete();
      prevStall = 1'b0;
      prevReq   = '{addr: '0, data: '0, write: 1'b0};
      readOut   = 1'b0;
      delay     = 0;
      readsSent = 0;
      stallLeft = 5;
      doneCount = 0;
      doneCycle = -1;

      checkOutput("launch_ready_idle", 32'(launchReady), 32'd1);
      if (sameCycleWrite) begin
         idx       = 2'($urandom_range(0, NumCfg - 1));
         wdata     = $urandom;
         cfgWrEn   = 1'b1;
         cfgWrIdx  = idx;
         cfgWrData = wdata;
         shadowModel[idx] = wdata;
      end
      launchValid = 1'b1;
      @(negedge clk);
      launchValid = 1'b0;
      cfgWrEn     = 1'b0;

      for (int i = 0; i < int'(NumCfg); i++) begin
         expList.push_back('{addr: BaseAddr + 32'(i), data: shadowModel[i], write: 1'b1});
      end
      expList.push_back('{addr: StartAddr, data: 32'h1, write: 1'b1});
      expReads   = (busyCount + 1 < int'(MaxPollsA)) ? busyCount + 1 : int'(MaxPollsA);
      timeoutExp = (busyCount >= int'(MaxPollsA));
      for (int i = 0; i < expReads; i++) begin
         expList.push_back('{addr: StatusAddr, data: 32'h0, write: 1'b0});
      end

      for (int cycle = 1; cycle <= CycleLimit; cycle++) begin
         if (cycle == 1) begin
            checkOutput("busy_after_launch", 32'(busy), 32'd1);
            checkOutput("launch_ready_busy", 32'(launchReady), 32'd0);
            checkOutput("error_cleared", 32'(error), 32'd0);
         end
         if (busyWrite && cycle == 1) begin
            cfgWrEn   = 1'b1;
            cfgWrIdx  = 2'd1;
            cfgWrData = ~shadowModel[1];
         end else begin
            cfgWrEn = 1'b0;
         end

         if (prevStall) begin
            checkOutput("stall_valid", 32'(reqValid), 32'd1);
            checkOutput("stall_addr", reqAddr, prevReq.addr);
            checkOutput("stall_data", reqData, prevReq.data);
            checkOutput("stall_write", 32'(reqWrite), 32'(prevReq.write));
         end
         checkOutput("rsp_ready", 32'(rspReady), 32'(readOut));
         if (reqValid && rspReady) begin
            checkOutput("req_rsp_exclusive", 32'd1, 32'd0);
         end
         if (done) begin
            doneCount++;
            doneCycle = cycle;
         end

         if (readOut && delay == 0) begin
            rspValid = 1'b1;
            rspData  = (readsSent <= busyCount) ? ($urandom | 32'h1) : ($urandom & ~32'h1);
            readOut  = 1'b0;
         end else begin
            if (readOut) delay--;
            rspValid = 1'b0;
            rspData  = $urandom | 32'h1;
         end

         if (reqValid && stallWord >= 0 && reqAddr == BaseAddr + 32'(stallWord) &&
             stallLeft > 0) begin
            reqReady = 1'b0;
            stallLeft--;
         end else begin
            reqReady = randomReady ? ($urandom_range(0, 3) != 0) : 1'b1;
         end

         cur = '{addr: reqAddr, data: reqData, write: reqWrite};
         if (reqValid && reqReady) begin
            reqLog.push_back(cur);
            if (!reqWrite) begin
               readsSent++;
               readOut = 1'b1;
               delay   = (maxDelay > 0) ? $urandom_range(0, maxDelay) : 0;
            end
            prevStall = 1'b0;
         end else begin
            prevStall = reqValid;
         end
         prevReq = cur;

         if (doneCount > 0 && cycle >= doneCycle + 2) break;
         @(negedge clk);
      end
      rspValid = 1'b0;
      reqReady = 1'b1;
      cfgWrEn  = 1'b0;

      checkOutput("done_pulses", 32'(doneCount), 32'd1);
      checkOutput("req_count", 32'(reqLog.size()), 32'(expList.size()));
      for (int i = 0; i < expList.size() && i < reqLog.size(); i++) begin
         checkOutput($sformatf("req%0d_addr", i), reqLog[i].addr, expList[i].addr);
         checkOutput($sformatf("req%0d_data", i), reqLog[i].data, expList[i].data);
         checkOutput($sformatf("req%0d_write", i), 32'(reqLog[i].write), 32'(expList[i].write));
      end
      checkOutput("error_flag", 32'(error), 32'(timeoutExp));
      checkOutput("ready_after_done", 32'(launchReady), 32'd1);
      if (stallWord < 0 && !randomReady && maxDelay == 0 && busyCount == 0) begin
         checkOutput("latency", 32'(doneCycle), 32'(NumCfg + 4));
      end
   endtask

   // Reset while waiting in POLL_RSP: the sequence must vanish without a
   // done pulse and the shadow file must come back as all zeros.
   task automatic resetMidPoll();
      bit reached;
      reached     = 1'b0;
      reqReady    = 1'b1;
      rspValid    = 1'b0;
      launchValid = 1'b1;
      @(negedge clk);
      launchValid = 1'b0;
      for (int cycle = 0; cycle < CycleLimit; cycle++) begin
         if (rspReady) begin
            reached = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("reached_poll_rsp", 32'(reached), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < int'(NumCfg); i++) shadowModel[i] = '0;
      checkOutput("rst_launch_ready", 32'(launchReady), 32'd1);
      checkOutput("rst_req_valid", 32'(reqValid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_rsp_ready", 32'(rspReady), 32'd0);
      checkOutput("rst_req_addr", reqAddr, 32'd0);
      @(negedge clk);
      checkOutput("rst_no_done_later", 32'(done), 32'd0);
   endtask

   // Timeout on instance B: the streamer never goes idle, so each launch
   // makes exactly MaxPollsB reads, flags an error and still finishes.
   task automatic runTimeoutB(input string tag);
      int  r0;
      int  d0;
      bit  seen;
      r0   = readsB;
      d0   = donesB;
      seen = 1'b0;
      launchValidB = 1'b1;
      @(negedge clk);
      launchValidB = 1'b0;
      checkOutput({tag, "_error_cleared"}, 32'(errorB), 32'd0);
      for (int cycle = 0; cycle < CycleLimit; cycle++) begin
         if (doneB) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      checkOutput({tag, "_reads"}, 32'(readsB - r0), 32'(MaxPollsB));
      checkOutput({tag, "_dones"}, 32'(donesB - d0), 32'd1);
      checkOutput({tag, "_error_set"}, 32'(errorB), 32'd1);
   endtask

   initial begin
      rst          = 1'b1;
      cfgWrEn      = 1'b0;
      cfgWrIdx     = '0;
      cfgWrData    = '0;
      launchValid  = 1'b0;
      reqReady     = 1'b1;
      rspData      = '0;
      rspValid     = 1'b0;
      launchValidB = 1'b0;
      reqReadyB    = 1'b1;
      rspDataB     = 32'h3;
      rspValidB    = 1'b1;
      cfgWrEnB     = 1'b0;
      cfgWrIdxB    = '0;
      cfgWrDataB   = '0;
      for (int i = 0; i < int'(NumCfg); i++) shadowModel[i] = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_error", 32'(error), 32'd0);
      checkOutput("reset_req_valid", 32'(reqValid), 32'd0);
      checkOutput("reset_rsp_ready", 32'(rspReady), 32'd0);
      checkOutput("reset_req_addr", reqAddr, 32'd0);
      checkOutput("reset_req_data", reqData, 32'd0);
      checkOutput("reset_req_write", 32'(reqWrite), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("launch_ready_after_reset", 32'(launchReady), 32'd1);

      $display("[TB] basic launch with shadow {A,B,C,D}");
      for (int i = 0; i < int'(NumCfg); i++) applyStimulus(2'(i), $urandom);
      runLaunch(-1, 0, 1'b0, 0, 1'b0, 1'b0);

      $display("[TB] ready stall on word 2");
      runLaunch(2, 0, 1'b0, 0, 1'b0, 1'b0);

      $display("[TB] status busy three times");
      runLaunch(-1, 3, 1'b0, 2, 1'b0, 1'b0);

      $display("[TB] shadow write while busy plus same-cycle write on launch");
      runLaunch(-1, 0, 1'b0, 0, 1'b1, 1'b1);
      runLaunch(-1, 0, 1'b0, 0, 1'b0, 1'b0);

      $display("[TB] randomized launches");
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 1) == 1) applyStimulus(2'($urandom_range(0, NumCfg - 1)), $urandom);
         runLaunch(-1, $urandom_range(0, 4), 1'b1, 2, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end

      $display("[TB] poll timeout on instance A then recovery");
      runLaunch(-1, MaxPollsA, 1'b0, 1, 1'b0, 1'b0);
      runLaunch(-1, 0, 1'b0, 0, 1'b0, 1'b0);

      $display("[TB] reset during POLL_RSP");
      resetMidPoll();
      runLaunch(-1, 0, 1'b0, 0, 1'b0, 1'b0);

      $display("[TB] poll timeout on instance B");
      runTimeoutB("timeoutB1");
      runTimeoutB("timeoutB2");

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
